// File: rtl/types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : types_pkg
// Brief    : Shared datapath types for the ALU and the ALU request arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package types_pkg;

    localparam int XLEN         = 32;
    localparam int SHIFT_AMOUNT = $clog2(XLEN);

    typedef logic        [XLEN-1:0] word_t;
    typedef logic signed [XLEN-1:0] signed_word_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_e;

    typedef struct packed {
        word_t  a;
        word_t  b;
        aluop_e op;
    } alu_req_t;

    typedef struct packed {
        word_t result;
        logic  zero;
    } alu_rsp_t;

endpackage : types_pkg
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Brief    : Single-cycle combinational integer ALU with zero flag.
// Revision : 1.0 - initial release
// ============================================================================
module alu
    import types_pkg::*;
(
    input  word_t        i_a,
    input  word_t        i_b,
    input  aluop_e       i_op,
    output signed_word_t o_result,
    output logic         o_zero
);

    signed_word_t                  w_res;
    logic [SHIFT_AMOUNT-1:0]       w_shamt;

    assign w_shamt = i_b[SHIFT_AMOUNT-1:0];

    always_comb begin
        w_res = '0;
        case (i_op)
            ALU_ADD:  w_res = signed'(i_a + i_b);
            ALU_SUB:  w_res = signed'(i_a - i_b);
            ALU_AND:  w_res = signed'(i_a & i_b);
            ALU_OR:   w_res = signed'(i_a | i_b);
            ALU_XOR:  w_res = signed'(i_a ^ i_b);
            ALU_SLL:  w_res = signed'(i_a << w_shamt);
            ALU_SRL:  w_res = signed'(i_a >> w_shamt);
            ALU_SRA:  w_res = signed'(i_a) >>> w_shamt;
            ALU_SLT:  w_res = (signed'(i_a) < signed'(i_b)) ? signed_word_t'(1) : '0;
            ALU_SLTU: w_res = (i_a < i_b) ? signed_word_t'(1) : '0;
            // Unencoded opcodes produce zero rather than an error
            default:  w_res = '0;
        endcase
    end

    assign o_result = w_res;
    assign o_zero   = (w_res == '0);

endmodule : alu
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter; searches upward from last+1.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_eligible,
    input  logic [IDX_W-1:0]   i_last_idx,
    output logic [NUM_REQ-1:0] o_grant_oh,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_grant_valid
);

    int w_cand;

    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_idx   = '0;
        w_cand        = 0;
        // Distance 1..NUM_REQ so the last winner is considered only last
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = (int'(i_last_idx) + k) % NUM_REQ;
            if (!o_grant_valid && i_eligible[IDX_W'(w_cand)]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = IDX_W'(w_cand);
            end
        end
    end

    always_comb begin
        o_grant_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            o_grant_oh[i] = o_grant_valid && (o_grant_idx == IDX_W'(i));
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Shares one ALU among NUM_REQ requesters with round-robin issue
//            and a one-entry registered response slot per requester.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import types_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid_i,
    output logic [NUM_REQ-1:0] req_ready_o,
    input  word_t              req_a_i      [NUM_REQ],
    input  word_t              req_b_i      [NUM_REQ],
    input  aluop_e             req_op_i     [NUM_REQ],
    output logic [NUM_REQ-1:0] rsp_valid_o,
    input  logic [NUM_REQ-1:0] rsp_ready_i,
    output word_t              rsp_result_o [NUM_REQ],
    output logic [NUM_REQ-1:0] rsp_zero_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               busy_o
);

    localparam logic [IDX_W-1:0] c_IDX_RESET = IDX_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0] w_eligible;
    logic [NUM_REQ-1:0] w_grant_oh;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_grant_valid;
    alu_req_t           w_req [NUM_REQ];
    alu_req_t           w_issue;
    signed_word_t       w_alu_result;
    logic               w_alu_zero;
    alu_rsp_t           w_alu_rsp;

    alu_rsp_t           r_rsp       [NUM_REQ];
    logic               r_rsp_valid [NUM_REQ];
    logic [IDX_W-1:0]   r_grant_idx;

    // A slot accepts when empty or being drained this cycle; nothing is eligible in reset
    assign w_eligible = {NUM_REQ{rst_n}} & req_valid_i & (~rsp_valid_o | rsp_ready_i);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_eligible    (w_eligible),
        .i_last_idx    (r_grant_idx),
        .o_grant_oh    (w_grant_oh),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    assign req_ready_o = w_grant_oh;
    assign w_issue     = w_req[w_grant_idx];

    alu u_alu (
        .i_a      (w_issue.a),
        .i_b      (w_issue.b),
        .i_op     (w_issue.op),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

    assign w_alu_rsp.result = $unsigned(w_alu_result);
    assign w_alu_rsp.zero   = w_alu_zero;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
        assign w_req[gi].a  = req_a_i[gi];
        assign w_req[gi].b  = req_b_i[gi];
        assign w_req[gi].op = req_op_i[gi];

        // Refill takes priority over a same-cycle pop
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_rsp[gi]       <= '0;
                r_rsp_valid[gi] <= 1'b0;
            end else if (w_grant_oh[gi]) begin
                r_rsp[gi]       <= w_alu_rsp;
                r_rsp_valid[gi] <= 1'b1;
            end else if (rsp_ready_i[gi]) begin
                r_rsp_valid[gi] <= 1'b0;
            end
        end

        assign rsp_valid_o[gi]  = r_rsp_valid[gi];
        assign rsp_result_o[gi] = r_rsp[gi].result;
        assign rsp_zero_o[gi]   = r_rsp[gi].zero;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant_idx <= c_IDX_RESET;
        end else if (w_grant_valid) begin
            r_grant_idx <= w_grant_idx;
        end
    end

    assign grant_idx_o = r_grant_idx;
    assign busy_o      = |rsp_valid_o;

endmodule : alu_arbiter
`default_nettype wire
